// File: rtl/serial_pkg.sv
// Shared definitions for the buffered serial port: status bit positions,
// FSM state encodings and the control-register master-reset code.
package serial_pkg;

    localparam int ST_RDRF = 0;
    localparam int ST_TDRE = 1;
    localparam int ST_FE   = 4;
    localparam int ST_OVR  = 5;
    localparam int ST_IRQ  = 7;

    localparam logic [1:0] MASTER_RESET_CODE = 2'b11;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; pointers wrap modulo DEPTH
// (power of two), so a simultaneous push and pop leaves the count unchanged.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_reg == FULL_COUNT);
    assign empty   = (count_reg == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // Head is read asynchronously so a read strobe captures it in the same clk it pops.
    assign head = mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/serial_fifo_io.sv
// Bus-compatible 8N1 serial port with a receive FIFO, single-byte transmit
// holding register, sticky FE/OVR flags and a receive interrupt.
module serial_fifo_io
    import serial_pkg::*;
#(
    parameter int BAUD_DIV   = 16,
    parameter int FIFO_DEPTH = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ce,
    input  logic       addr,
    input  logic [7:0] data_in,
    input  logic       rd,
    input  logic       we,
    output logic [7:0] data_out,
    input  logic       rx,
    output logic       tx,
    output logic       irq
);

    localparam int CW = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] BIT_LAST  = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(BAUD_DIV / 2 - 1);

    logic       srst;
    logic       ctrl_wr;
    logic       master_reset;
    logic       data_wr;
    logic       status_rd;
    logic       data_rd;
    logic [7:0] status;

    logic       fifo_full;
    logic       fifo_empty;
    logic [7:0] fifo_head;
    logic       rx_push;
    logic       set_fe;
    logic       set_ovr;

    logic [7:0] data_out_reg;
    logic       rie_reg;
    logic       fe_reg;
    logic       ovr_reg;
    logic       irq_reg;

    logic       rx_meta_reg, rx_sync_reg, rx_prev_reg;
    rx_state_t  rx_state_reg, rx_state_next;
    logic [CW-1:0] rx_cnt_reg, rx_cnt_next;
    logic [2:0] rx_bit_reg, rx_bit_next;
    logic [7:0] rx_shift_reg, rx_shift_next;

    tx_state_t  tx_state_reg, tx_state_next;
    logic [CW-1:0] tx_cnt_reg, tx_cnt_next;
    logic [2:0] tx_bit_reg, tx_bit_next;
    logic [7:0] tx_shift_reg, tx_shift_next;
    logic [7:0] hold_reg, hold_next;
    logic       tdre_reg, tdre_next;
    logic       tx_reg, tx_next;

    assign ctrl_wr      = ce & we & ~addr;
    assign master_reset = ctrl_wr & (data_in[1:0] == MASTER_RESET_CODE);
    assign srst         = reset | master_reset;
    assign data_wr      = ce & we & addr & tdre_reg;
    assign status_rd    = ce & rd & ~addr;
    assign data_rd      = ce & rd & addr;

    assign data_out = data_out_reg;
    assign tx       = tx_reg;
    assign irq      = irq_reg;

    always_comb begin
        status          = 8'h00;
        status[ST_RDRF] = ~fifo_empty;
        status[ST_TDRE] = tdre_reg;
        status[ST_FE]   = fe_reg;
        status[ST_OVR]  = ovr_reg;
        status[ST_IRQ]  = irq_reg;
    end

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_rx_fifo (
        .clk       (clk),
        .srst      (srst),
        .push      (rx_push),
        .push_data (rx_shift_reg),
        .pop       (data_rd),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (fifo_head)
    );

    // A new error event wins over a status-read clear in the same clk so it is never lost.
    always_ff @(posedge clk) begin
        if (srst) begin
            data_out_reg <= 8'h00;
            rie_reg      <= 1'b0;
            fe_reg       <= 1'b0;
            ovr_reg      <= 1'b0;
            irq_reg      <= 1'b0;
        end else begin
            if (rd) begin
                data_out_reg <= addr ? (fifo_empty ? 8'h00 : fifo_head) : status;
            end
            if (ctrl_wr) begin
                rie_reg <= data_in[7];
            end
            irq_reg <= rie_reg & ~fifo_empty;
            if (set_fe) begin
                fe_reg <= 1'b1;
            end else if (status_rd) begin
                fe_reg <= 1'b0;
            end
            if (set_ovr) begin
                ovr_reg <= 1'b1;
            end else if (status_rd) begin
                ovr_reg <= 1'b0;
            end
        end
    end

    // Receiver: two-flop synchroniser plus one more stage for falling-edge detection.
    always_ff @(posedge clk) begin
        if (srst) begin
            rx_meta_reg  <= 1'b1;
            rx_sync_reg  <= 1'b1;
            rx_prev_reg  <= 1'b1;
            rx_state_reg <= RX_IDLE;
            rx_cnt_reg   <= '0;
            rx_bit_reg   <= '0;
            rx_shift_reg <= '0;
        end else begin
            rx_meta_reg  <= rx;
            rx_sync_reg  <= rx_meta_reg;
            rx_prev_reg  <= rx_sync_reg;
            rx_state_reg <= rx_state_next;
            rx_cnt_reg   <= rx_cnt_next;
            rx_bit_reg   <= rx_bit_next;
            rx_shift_reg <= rx_shift_next;
        end
    end

    always_comb begin
        rx_state_next = rx_state_reg;
        rx_cnt_next   = rx_cnt_reg;
        rx_bit_next   = rx_bit_reg;
        rx_shift_next = rx_shift_reg;
        rx_push       = 1'b0;
        set_fe        = 1'b0;
        set_ovr       = 1'b0;
        unique case (rx_state_reg)
            RX_IDLE: begin
                rx_cnt_next = '0;
                if (rx_prev_reg & ~rx_sync_reg) begin
                    rx_state_next = RX_START;
                end
            end
            RX_START: begin
                if (rx_cnt_reg == HALF_LAST) begin
                    rx_cnt_next   = '0;
                    rx_bit_next   = '0;
                    rx_state_next = rx_sync_reg ? RX_IDLE : RX_DATA;
                end else begin
                    rx_cnt_next = rx_cnt_reg + 1'b1;
                end
            end
            RX_DATA: begin
                if (rx_cnt_reg == BIT_LAST) begin
                    rx_cnt_next   = '0;
                    rx_shift_next = {rx_sync_reg, rx_shift_reg[7:1]};
                    rx_bit_next   = rx_bit_reg + 1'b1;
                    if (rx_bit_reg == 3'd7) begin
                        rx_state_next = RX_STOP;
                    end
                end else begin
                    rx_cnt_next = rx_cnt_reg + 1'b1;
                end
            end
            RX_STOP: begin
                if (rx_cnt_reg == BIT_LAST) begin
                    rx_cnt_next   = '0;
                    rx_state_next = RX_IDLE;
                    if (!rx_sync_reg) begin
                        set_fe = 1'b1;
                    end else if (fifo_full) begin
                        set_ovr = 1'b1;
                    end else begin
                        rx_push = 1'b1;
                    end
                end else begin
                    rx_cnt_next = rx_cnt_reg + 1'b1;
                end
            end
            default: rx_state_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            tx_state_reg <= TX_IDLE;
            tx_cnt_reg   <= '0;
            tx_bit_reg   <= '0;
            tx_shift_reg <= '0;
            hold_reg     <= '0;
            tdre_reg     <= 1'b1;
            tx_reg       <= 1'b1;
        end else begin
            tx_state_reg <= tx_state_next;
            tx_cnt_reg   <= tx_cnt_next;
            tx_bit_reg   <= tx_bit_next;
            tx_shift_reg <= tx_shift_next;
            hold_reg     <= hold_next;
            tdre_reg     <= tdre_next;
            tx_reg       <= tx_next;
        end
    end

    // A CPU write needs TDRE=1 and the FSM only takes the byte when TDRE=0, so they never collide.
    always_comb begin
        tx_state_next = tx_state_reg;
        tx_cnt_next   = tx_cnt_reg;
        tx_bit_next   = tx_bit_reg;
        tx_shift_next = tx_shift_reg;
        hold_next     = hold_reg;
        tdre_next     = tdre_reg;
        tx_next       = tx_reg;
        if (data_wr) begin
            hold_next = data_in;
            tdre_next = 1'b0;
        end
        unique case (tx_state_reg)
            TX_IDLE: begin
                if (!tdre_reg) begin
                    tx_shift_next = hold_reg;
                    tdre_next     = 1'b1;
                    tx_next       = 1'b0;
                    tx_cnt_next   = '0;
                    tx_state_next = TX_START;
                end
            end
            TX_START: begin
                if (tx_cnt_reg == BIT_LAST) begin
                    tx_cnt_next   = '0;
                    tx_bit_next   = '0;
                    tx_next       = tx_shift_reg[0];
                    tx_shift_next = {1'b0, tx_shift_reg[7:1]};
                    tx_state_next = TX_DATA;
                end else begin
                    tx_cnt_next = tx_cnt_reg + 1'b1;
                end
            end
            TX_DATA: begin
                if (tx_cnt_reg == BIT_LAST) begin
                    tx_cnt_next = '0;
                    if (tx_bit_reg == 3'd7) begin
                        tx_next       = 1'b1;
                        tx_state_next = TX_STOP;
                    end else begin
                        tx_next       = tx_shift_reg[0];
                        tx_shift_next = {1'b0, tx_shift_reg[7:1]};
                        tx_bit_next   = tx_bit_reg + 1'b1;
                    end
                end else begin
                    tx_cnt_next = tx_cnt_reg + 1'b1;
                end
            end
            TX_STOP: begin
                if (tx_cnt_reg == BIT_LAST) begin
                    tx_cnt_next = '0;
                    if (!tdre_reg) begin
                        tx_shift_next = hold_reg;
                        tdre_next     = 1'b1;
                        tx_next       = 1'b0;
                        tx_state_next = TX_START;
                    end else begin
                        tx_state_next = TX_IDLE;
                    end
                end else begin
                    tx_cnt_next = tx_cnt_reg + 1'b1;
                end
            end
            default: tx_state_next = TX_IDLE;
        endcase
    end

endmodule

// File: tb/tb_serial_fifo_io.sv
// Self-checking bench for serial_fifo_io with BAUD_DIV=4, FIFO_DEPTH=4;
// a queue-based model of the receive path and frame-level tx checks.
module tb_serial_fifo_io;

    localparam int BD    = 4;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       ce;
    logic       addr;
    logic [7:0] data_in;
    logic       rd;
    logic       we;
    logic [7:0] data_out;
    logic       rx;
    logic       tx;
    logic       irq;

    int total = 0;
    int bad   = 0;

    logic tx_log[$];
    bit   log_en = 1'b0;

    serial_fifo_io #(
        .BAUD_DIV   (BD),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .ce       (ce),
        .addr     (addr),
        .data_in  (data_in),
        .rd       (rd),
        .we       (we),
        .data_out (data_out),
        .rx       (rx),
        .tx       (tx),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (log_en) tx_log.push_back(tx);
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected test completion");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic cpu_write(input logic a, input logic [7:0] d);
        ce = 1'b1; we = 1'b1; addr = a; data_in = d;
        tick();
        ce = 1'b0; we = 1'b0;
        $display("write addr=%0d data=%02h", a, d);
    endtask

    task automatic cpu_read(input logic a, output logic [7:0] d);
        ce = 1'b1; rd = 1'b1; addr = a;
        tick();
        ce = 1'b0; rd = 1'b0;
        d = data_out;
        $display("read  addr=%0d data=%02h", a, d);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int tail);
        rx = 1'b0;
        tick(BD);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            tick(BD);
        end
        rx = stop_bit;
        tick(BD);
        rx = 1'b1;
        tick(tail);
        $display("rx frame data=%02h stop=%0d", b, stop_bit);
    endtask

    function automatic logic frame_bit(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
        return 1'b1;
    endfunction

    // Model status value: TDRE assumed idle-empty, RIE off.
    function automatic logic [7:0] model_status(input int fifo_n, input bit fe, input bit ovr);
        return 8'h02 + ((fifo_n != 0) ? 8'h01 : 8'h00) + (fe ? 8'h10 : 8'h00) + (ovr ? 8'h20 : 8'h00);
    endfunction

    task automatic check_tx_frames(input string name, input logic [7:0] b0, input logic [7:0] b1,
                                   input int nframes);
        int start;
        int idx;
        logic exp_bit;
        logic [7:0] cur;
        start = -1;
        for (int i = 0; i < tx_log.size(); i++) begin
            if (tx_log[i] === 1'b0) begin
                start = i;
                break;
            end
        end
        total++;
        if (start < 0) begin
            bad++;
            $display("FAIL %s_start: got no start bit, required a 0 on tx", name);
            return;
        end
        for (int f = 0; f < nframes; f++) begin
            cur = (f == 0) ? b0 : b1;
            for (int j = 0; j < 10 * BD; j++) begin
                idx = start + f * 10 * BD + j;
                exp_bit = frame_bit(cur, j / BD);
                total++;
                if (idx >= tx_log.size() || tx_log[idx] !== exp_bit) begin
                    bad++;
                    $display("FAIL %s_frame%0d_sample%0d: got %b required %b", name, f, j,
                             (idx < tx_log.size()) ? tx_log[idx] : 1'bx, exp_bit);
                end
            end
        end
        idx = start + nframes * 10 * BD;
        total++;
        if (idx >= tx_log.size() || tx_log[idx] !== 1'b1) begin
            bad++;
            $display("FAIL %s_idle_after: tx not idle high after last frame", name);
        end
    endtask

    task automatic test_reset();
        logic [7:0] d;
        reset = 1'b1; rx = 1'b1; ce = 1'b0; rd = 1'b0; we = 1'b0; addr = 1'b0; data_in = 8'h00;
        tick(3);
        total++;
        if (tx !== 1'b1) begin bad++; $display("FAIL reset_tx: got %b required 1", tx); end
        total++;
        if (irq !== 1'b0) begin bad++; $display("FAIL reset_irq: got %b required 0", irq); end
        total++;
        if (data_out !== 8'h00) begin bad++; $display("FAIL reset_data_out: got %02h required 00", data_out); end
        reset = 1'b0;
        tick();
        cpu_read(1'b0, d);
        total++;
        if (d !== 8'h02) begin bad++; $display("FAIL reset_status: got %02h required 02", d); end
        cpu_read(1'b1, d);
        total++;
        if (d !== 8'h00) begin bad++; $display("FAIL reset_empty_read: got %02h required 00", d); end
    endtask

    task automatic test_tx_single();
        logic [7:0] d;
        tx_log.delete();
        log_en = 1'b1;
        cpu_write(1'b1, 8'h55);
        cpu_read(1'b0, d);
        total++;
        if (d !== 8'h00) begin bad++; $display("FAIL tx_tdre_low: got %02h required 00", d); end
        cpu_read(1'b0, d);
        total++;
        if (d !== 8'h02) begin bad++; $display("FAIL tx_tdre_back: got %02h required 02", d); end
        tick(45);
        log_en = 1'b0;
        check_tx_frames("tx55", 8'h55, 8'h00, 1);
    endtask

    task automatic test_rx_basic();
        logic [7:0] d;
        send_frame(8'hA5, 1'b1, 4);
        cpu_read(1'b0, d);
        total++;
        if (d !== 8'h03) begin bad++; $display("FAIL rx_status_full: got %02h required 03", d); end
        cpu_read(1'b1, d);
        total++;
        if (d !== 8'hA5) begin bad++; $display("FAIL rx_data: got %02h required a5", d); end
        cpu_read(1'b0, d);
        total++;
        if (d !== 8'h02) begin bad++; $display("FAIL rx_status_empty: got %02h required 02", d); end
    endtask

    task automatic test_irq();
        logic [7:0] d;
        int waited;
        cpu_write(1'b0, 8'h80);
        tick(2);
        total++;
        if (irq !== 1'b0) begin bad++; $display("FAIL irq_idle: got %b required 0", irq); end
        send_frame(8'h3C, 1'b1, 0);
        waited = 0;
        while (irq !== 1'b1 && waited < 4) begin
            tick();
            waited++;
        end
        total++;
        if (irq !== 1'b1) begin bad++; $display("FAIL irq_rise: got %b required 1 within bound", irq); end
        cpu_read(1'b0, d);
        total++;
        if (d !== 8'h83) begin bad++; $display("FAIL irq_status: got %02h required 83", d); end
        cpu_read(1'b1, d);
        total++;
        if (d !== 8'h3C) begin bad++; $display("FAIL irq_data: got %02h required 3c", d); end
        total++;
        if (irq !== 1'b1) begin bad++; $display("FAIL irq_registered: got %b required 1 in pop clk", irq); end
        tick();
        total++;
        if (irq !== 1'b0) begin bad++; $display("FAIL irq_fall: got %b required 0", irq); end
        cpu_write(1'b0, 8'h00);
    endtask

    task automatic test_overrun();
        logic [7:0] d;
        logic [7:0] sent;
        logic [7:0] q[$];
        bit ovr;
        ovr = 1'b0;
        for (int i = 0; i < DEPTH + 1; i++) begin
            sent = 8'($urandom);
            send_frame(sent, 1'b1, 2);
            if (q.size() < DEPTH) q.push_back(sent);
            else ovr = 1'b1;
        end
        cpu_read(1'b0, d);
        total++;
        if (d !== model_status(q.size(), 1'b0, ovr)) begin
            bad++; $display("FAIL ovr_status: got %02h required %02h", d, model_status(q.size(), 1'b0, ovr));
        end
        while (q.size() != 0) begin
            cpu_read(1'b1, d);
            total++;
            if (d !== q[0]) begin bad++; $display("FAIL ovr_data: got %02h required %02h", d, q[0]); end
            void'(q.pop_front());
        end
        cpu_read(1'b1, d);
        total++;
        if (d !== 8'h00) begin bad++; $display("FAIL ovr_fifth_lost: got %02h required 00", d); end
        cpu_read(1'b0, d);
        total++;
        if (d !== 8'h02) begin bad++; $display("FAIL ovr_cleared: got %02h required 02", d); end
    endtask

    task automatic test_framing();
        logic [7:0] d;
        send_frame(8'($urandom), 1'b0, 4);
        cpu_read(1'b0, d);
        total++;
        if (d !== 8'h12) begin bad++; $display("FAIL fe_status: got %02h required 12", d); end
        cpu_read(1'b0, d);
        total++;
        if (d !== 8'h02) begin bad++; $display("FAIL fe_cleared: got %02h required 02", d); end
        cpu_read(1'b1, d);
        total++;
        if (d !== 8'h00) begin bad++; $display("FAIL fe_no_push: got %02h required 00", d); end
    endtask

    task automatic test_back_to_back();
        tx_log.delete();
        log_en = 1'b1;
        cpu_write(1'b1, 8'h11);
        tick();
        cpu_write(1'b1, 8'h22);
        tick(85);
        log_en = 1'b0;
        check_tx_frames("b2b", 8'h11, 8'h22, 2);
    endtask

    task automatic test_master_reset();
        logic [7:0] d;
        send_frame(8'h5A, 1'b1, 4);
        cpu_write(1'b0, 8'h80);
        cpu_write(1'b1, 8'h11);
        tick();
        cpu_write(1'b1, 8'h22);
        tick(9);
        cpu_write(1'b0, 8'h03);
        total++;
        if (tx !== 1'b1) begin bad++; $display("FAIL mrst_tx: got %b required 1", tx); end
        total++;
        if (data_out !== 8'h00) begin bad++; $display("FAIL mrst_data_out: got %02h required 00", data_out); end
        total++;
        if (irq !== 1'b0) begin bad++; $display("FAIL mrst_irq: got %b required 0", irq); end
        tx_log.delete();
        log_en = 1'b1;
        tick(50);
        log_en = 1'b0;
        total++;
        if (tx_log.size() == 0 || tx_log.sum() with (int'(item)) != tx_log.size()) begin
            bad++; $display("FAIL mrst_tx_idle: got a low tx sample, required idle high");
        end
        cpu_read(1'b0, d);
        total++;
        if (d !== 8'h02) begin bad++; $display("FAIL mrst_status: got %02h required 02", d); end
        cpu_read(1'b1, d);
        total++;
        if (d !== 8'h00) begin bad++; $display("FAIL mrst_fifo_empty: got %02h required 00", d); end
        send_frame(8'h77, 1'b1, 4);
        total++;
        if (irq !== 1'b0) begin bad++; $display("FAIL mrst_rie_cleared: got %b required 0", irq); end
        cpu_read(1'b1, d);
        total++;
        if (d !== 8'h77) begin bad++; $display("FAIL mrst_rx_after: got %02h required 77", d); end
    endtask

    task automatic test_port_reset_abort();
        logic [7:0] d;
        rx = 1'b0;
        tick(BD);
        rx = 1'b1; tick(BD);
        rx = 1'b0; tick(BD);
        cpu_write(1'b1, 8'h00);
        tick(10);
        reset = 1'b1;
        rx = 1'b1;
        tick();
        total++;
        if (tx !== 1'b1) begin bad++; $display("FAIL prst_tx: got %b required 1", tx); end
        reset = 1'b0;
        tick(50);
        cpu_read(1'b0, d);
        total++;
        if (d !== 8'h02) begin bad++; $display("FAIL prst_status: got %02h required 02", d); end
    endtask

    task automatic test_random();
        logic [7:0] d;
        logic [7:0] b;
        logic stop_bit;
        logic [7:0] q[$];
        bit fe;
        bit ovr;
        int n;
        for (int r = 0; r < 6; r++) begin
            fe = 1'b0;
            ovr = 1'b0;
            n = int'($urandom_range(1, 6));
            for (int i = 0; i < n; i++) begin
                b = 8'($urandom);
                stop_bit = ($urandom_range(0, 4) != 0);
                send_frame(b, stop_bit, 2);
                if (!stop_bit) fe = 1'b1;
                else if (q.size() < DEPTH) q.push_back(b);
                else ovr = 1'b1;
            end
            cpu_read(1'b0, d);
            total++;
            if (d !== model_status(q.size(), fe, ovr)) begin
                bad++; $display("FAIL rand%0d_status: got %02h required %02h", r, d, model_status(q.size(), fe, ovr));
            end
            while (q.size() != 0) begin
                cpu_read(1'b1, d);
                total++;
                if (d !== q[0]) begin bad++; $display("FAIL rand%0d_data: got %02h required %02h", r, d, q[0]); end
                void'(q.pop_front());
            end
            cpu_read(1'b1, d);
            total++;
            if (d !== 8'h00) begin bad++; $display("FAIL rand%0d_empty: got %02h required 00", r, d); end
        end
    endtask

    initial begin
        test_reset();
        test_tx_single();
        test_rx_basic();
        test_irq();
        test_overrun();
        test_framing();
        test_back_to_back();
        test_master_reset();
        test_port_reset_abort();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
